// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared types and constants for the data memory responder
// Contents: FSM state type, DEPTH/LATENCY defaults, word/address/index widths,
// and a helper that sizes the storage index from DEPTH.
package mem_pkg;
    localparam int WORD_W          = 32;
    localparam int ADDR_W          = 32;
    localparam int INDEX_W         = ADDR_W - 2;
    localparam int DEFAULT_DEPTH   = 64;
    localparam int DEFAULT_LATENCY = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int index_bits(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between MEM stage and data memory
// Signals: req_valid/req_write/req_addr/req_wdata (requester -> responder),
// req_ready/resp_valid/resp_rdata/resp_error/stall (responder -> requester).
// Modports: master = MEM stage, slave = responder.
interface data_mem_responder_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_error;
    logic              stall;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error, stall
    );
endinterface

// File: rtl/dm_storage_array.sv
// rtl/dm_storage_array.sv - word storage with synchronous write, registered read, synchronous clear
// Ports: clock; clear (sync, clears every word and the read register);
// wr_en/index/wdata write port; rd_strobe updates rdata, with rd_en selecting
// mem[index] or zero; rdata holds between strobes.
module dm_storage_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = index_bits(DEFAULT_DEPTH)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              wr_en,
    input  logic              rd_strobe,
    input  logic              rd_en,
    input  logic [AW-1:0]     index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (wr_en) begin
                mem[index] <= wdata;
            end
            // Stores and faulted accesses still strobe, returning zero.
            if (rd_strobe) begin
                rdata <= rd_en ? mem[index] : '0;
            end
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data memory responder for the MEM stage
// Ports: clock, reset (sync, active-high), bus (data_mem_responder_if.slave).
// One request in flight; response pulses LATENCY edges after accept; a new
// request may be accepted in the response cycle.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                  clock,
    input  logic                  reset,
    data_mem_responder_if.slave   bus
);
    localparam int               AW       = index_bits(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              write_q;
    logic              ready_q;
    logic              resp_valid_q;
    logic              resp_error_q;
    logic [WORD_W-1:0] rdata;
    logic              access_err;
    logic              finish;

    assign access_err = (addr_q[1:0] != 2'b00) || (addr_q[ADDR_W-1:2] >= INDEX_W'(DEPTH));
    // The edge that ends the last BUSY cycle is the one entering RESP.
    assign finish     = (state == BUSY) && (count == '0);

    dm_storage_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clock     (clock),
        .clear     (reset),
        .wr_en     (finish && write_q && !access_err),
        .rd_strobe (finish),
        .rd_en     (!write_q && !access_err),
        .index     (addr_q[AW+1:2]),
        .wdata     (wdata_q),
        .rdata     (rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        write_q <= bus.req_write;
                        count   <= CNT_LOAD;
                        state   <= BUSY;
                        ready_q <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state        <= RESP;
                        ready_q      <= 1'b1;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= access_err;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata;
    assign bus.resp_error = resp_error_q;
    // Freeze MEM/WB while a request is waiting or in flight; release in RESP.
    assign bus.stall      = bus.req_valid && !reset && (state != RESP);
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (LATENCY 2 and 1 builds)
module tb_data_mem_responder;
    localparam int LAT1 = 2;
    localparam int LAT2 = 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q1[$];
    exp_t q2[$];

    data_mem_responder_if bus1();
    data_mem_responder_if bus2();

    data_mem_responder #(.DEPTH(64), .LATENCY(LAT1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    data_mem_responder #(.DEPTH(64), .LATENCY(LAT2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(posedge clock) begin : mon1
        bit due;
        #1;
        due = (q1.size() > 0) && (q1[0].cyc == cyc);
        check("resp_valid_l2", 32'(bus1.resp_valid), 32'(due));
        check("stall_l2", 32'(bus1.stall), 32'(!reset && bus1.req_valid && !due));
        if (due) begin
            check("resp_rdata_l2", bus1.resp_rdata, q1[0].rdata);
            check("resp_error_l2", 32'(bus1.resp_error), 32'(q1[0].err));
            void'(q1.pop_front());
        end
    end

    always @(posedge clock) begin : mon2
        bit due;
        #1;
        due = (q2.size() > 0) && (q2[0].cyc == cyc);
        check("resp_valid_l1", 32'(bus2.resp_valid), 32'(due));
        check("stall_l1", 32'(bus2.stall), 32'(!reset && bus2.req_valid && !due));
        if (due) begin
            check("resp_rdata_l1", bus2.resp_rdata, q2[0].rdata);
            check("resp_error_l1", 32'(bus2.resp_error), 32'(q2[0].err));
            void'(q2.pop_front());
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic ee, input bit hold, output int acc);
        int   n = 0;
        logic rdy;
        exp_t e;
        if (sel == 1) begin
            bus1.req_valid = 1'b1; bus1.req_write = w; bus1.req_addr = a; bus1.req_wdata = d;
        end else begin
            bus2.req_valid = 1'b1; bus2.req_write = w; bus2.req_addr = a; bus2.req_wdata = d;
        end
        rdy = (sel == 1) ? bus1.req_ready : bus2.req_ready;
        while (!rdy && n < 40) begin
            @(negedge clock);
            n++;
            rdy = (sel == 1) ? bus1.req_ready : bus2.req_ready;
        end
        acc = cyc + 1;
        if (!rdy) begin
            check("accept_timeout", 32'(rdy), 32'd1);
        end else begin
            e.rdata = er;
            e.err   = ee;
            e.cyc   = acc + ((sel == 1) ? LAT1 : LAT2);
            if (sel == 1) q1.push_back(e);
            else          q2.push_back(e);
        end
        @(negedge clock);
        if (!hold) begin
            if (sel == 1) bus1.req_valid = 1'b0;
            else          bus2.req_valid = 1'b0;
        end
    endtask

    task automatic drain(input int sel);
        int n = 0;
        while (((sel == 1) ? q1.size() : q2.size()) != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) begin
            check("drain_timeout", 32'((sel == 1) ? q1.size() : q2.size()), 32'd0);
            if (sel == 1) q1.delete();
            else          q2.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        int a0, a1, a2, a3;
        reset = 1'b1;
        bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
        @(negedge clock);
        check("rst_req_ready", 32'(bus1.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus1.resp_valid), 32'd0);
        check("rst_resp_rdata", bus1.resp_rdata, 32'd0);
        check("rst_resp_error", 32'(bus1.resp_error), 32'd0);
        check("rst_stall", 32'(bus1.stall), 32'd0);
        @(negedge clock);
        bus1.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);

        // Stores, then loads back
        issue(1, 1'b1, 32'h0, 32'h0000FFFF, 32'h0, 1'b0, 1'b0, a0); drain(1);
        issue(1, 1'b1, 32'h4, 32'h0000EEEE, 32'h0, 1'b0, 1'b0, a0); drain(1);
        issue(1, 1'b1, 32'h8, 32'h0000DDDD, 32'h0, 1'b0, 1'b0, a0); drain(1);
        issue(1, 1'b0, 32'h0, 32'h0, 32'h0000FFFF, 1'b0, 1'b0, a0); drain(1);
        issue(1, 1'b0, 32'h4, 32'h0, 32'h0000EEEE, 1'b0, 1'b0, a0); drain(1);
        issue(1, 1'b0, 32'h8, 32'h0, 32'h0000DDDD, 1'b0, 1'b0, a0); drain(1);
        repeat (3) @(negedge clock);
        check("rdata_hold", bus1.resp_rdata, 32'h0000DDDD);

        // Misaligned and out-of-range accesses
        issue(1, 1'b1, 32'h2,   32'hBADBAD01, 32'h0, 1'b1, 1'b0, a0); drain(1);
        issue(1, 1'b0, 32'h100, 32'h0,        32'h0, 1'b1, 1'b0, a0); drain(1);
        issue(1, 1'b1, 32'h100, 32'hBADBAD02, 32'h0, 1'b1, 1'b0, a0); drain(1);
        issue(1, 1'b0, 32'h0,   32'h0, 32'h0000FFFF, 1'b0, 1'b0, a0); drain(1);
        issue(1, 1'b0, 32'h4,   32'h0, 32'h0000EEEE, 1'b0, 1'b0, a0); drain(1);

        // Back-to-back with req_valid held high
        issue(1, 1'b1, 32'h10, 32'h000000A1, 32'h0, 1'b0, 1'b1, a0);
        issue(1, 1'b0, 32'h10, 32'h0, 32'h000000A1, 1'b0, 1'b1, a1);
        issue(1, 1'b1, 32'h14, 32'h000000B2, 32'h0, 1'b0, 1'b1, a2);
        issue(1, 1'b0, 32'h14, 32'h0, 32'h000000B2, 1'b0, 1'b0, a3);
        drain(1);
        check("b2b_gap_1", 32'(a1 - a0), 32'(LAT1 + 1));
        check("b2b_gap_2", 32'(a2 - a1), 32'(LAT1 + 1));
        check("b2b_gap_3", 32'(a3 - a2), 32'(LAT1 + 1));

        // Reset one cycle after accepting a store abandons it
        issue(1, 1'b1, 32'hC, 32'h12345678, 32'h0, 1'b0, 1'b0, a0);
        reset = 1'b1;
        q1.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        issue(1, 1'b0, 32'hC, 32'h0, 32'h0, 1'b0, 1'b0, a0); drain(1);
        issue(1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, a0); drain(1);

        // LATENCY=1 build
        issue(2, 1'b1, 32'h4, 32'hCAFE0004, 32'h0, 1'b0, 1'b0, a0); drain(2);
        issue(2, 1'b0, 32'h4, 32'h0, 32'hCAFE0004, 1'b0, 1'b0, a0); drain(2);

        check("q1_empty", 32'(q1.size()), 32'd0);
        check("q2_empty", 32'(q2.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
